// File: rtl/test_mem_responder_pkg.sv
// Shared types and constants for the 4B memory responder: message layouts,
// request/test codes, byte-lane width and the random-delay LFSR constants.
package test_mem_responder_pkg;

    localparam logic [2:0] MEM_REQ_READ  = 3'd0;
    localparam logic [2:0] MEM_REQ_WRITE = 3'd1;
    localparam logic [2:0] MEM_REQ_INIT  = 3'd2;

    localparam logic [1:0] MEM_TEST_OK          = 2'b00;
    localparam logic [1:0] MEM_TEST_UNSUPPORTED = 2'b01;

    localparam int BYTE_LANES = 4;

    // Taps 16,14,13,11 expressed for a right-shifting register (bits 0,2,3,5).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    function automatic logic [2:0] byte_count(input logic [1:0] len);
        return (len == 2'd0) ? 3'd4 : {1'b0, len};
    endfunction

endpackage

// File: rtl/test_mem_responder_lane_align.sv
// Byte-lane steering: write mask/data placement and read extract/zero-extend
// from a byte offset and length code (len 0 = 4 bytes).
module test_mem_responder_lane_align
    import test_mem_responder_pkg::*;
(
    input  logic [1:0]  wr_offset,
    input  logic [1:0]  wr_len,
    input  logic [31:0] wr_data_in,
    output logic [3:0]  wr_mask,
    output logic [31:0] wr_data,
    input  logic [1:0]  rd_offset,
    input  logic [1:0]  rd_len,
    input  logic [31:0] rd_word,
    output logic [31:0] rd_data
);

    logic [2:0]  wr_end;
    logic [2:0]  rd_cnt;
    logic [31:0] rd_shifted;

    // Bytes shifted past lane 3 simply fall off the top of the word.
    assign wr_end     = {1'b0, wr_offset} + byte_count(wr_len);
    assign wr_data    = wr_data_in << {wr_offset, 3'b000};
    assign rd_cnt     = byte_count(rd_len);
    assign rd_shifted = rd_word >> {rd_offset, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
            assign wr_mask[gi] = (3'(gi) >= {1'b0, wr_offset}) && (3'(gi) < wr_end);
            assign rd_data[8*gi +: 8] = (3'(gi) < rd_cnt) ? rd_shifted[8*gi +: 8] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/test_mem_responder.sv
// Val/rdy memory responder: word array, fixed-latency pipeline and credit-managed
// response buffer. Define TEST_MEM_RESPONDER_RAND_DELAY_EN for LFSR response stalls.
module test_mem_responder
    import test_mem_responder_pkg::*;
#(
    parameter int p_num_words  = 1024,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] reqstream_msg,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    output logic [46:0] respstream_msg,
    output logic        respstream_val,
    input  logic        respstream_rdy,
    output logic [3:0]  num_outstanding
);

    localparam int IDX_W = $clog2(p_num_words);
    localparam int PTR_W = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;

    mem_req_4B_t       req;
    logic [IDX_W-1:0]  req_idx;
    logic              is_rd, is_wr;
    logic              accept, deliver, stall;
    logic [3:0]        count_reg;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data, rd_word, rd_data;
    logic              unused_addr_bits;

    assign req              = reqstream_msg;
    assign req_idx          = req.addr[IDX_W+1:2];
    assign unused_addr_bits = ^req.addr[31:IDX_W+2];
    assign is_rd            = (req.type_ == MEM_REQ_READ);
    assign is_wr            = (req.type_ == MEM_REQ_WRITE) || (req.type_ == MEM_REQ_INIT);

    // Credit depends only on registered state, never on respstream_rdy.
    assign reqstream_rdy   = reset && (count_reg < 4'(p_resp_depth));
    assign accept          = reqstream_val && reqstream_rdy;
    assign num_outstanding = reset ? count_reg : 4'd0;

    logic         s0_val_reg, s0_read_reg;
    logic [1:0]   s0_off_reg;
    mem_resp_4B_t s0_resp_reg, s0_resp_full;

    test_mem_responder_lane_align u_lane_align (
        .wr_offset  (req.addr[1:0]),
        .wr_len     (req.len),
        .wr_data_in (req.data),
        .wr_mask    (wr_mask),
        .wr_data    (wr_data),
        .rd_offset  (s0_off_reg),
        .rd_len     (s0_resp_reg.len),
        .rd_word    (rd_word),
        .rd_data    (rd_data)
    );

    // One byte-wide array per lane so each maps onto a block RAM with a plain write enable.
    genvar gi;
    generate
        for (gi = 0; gi < BYTE_LANES; gi++) begin : g_mem
            logic [7:0] lane_mem [p_num_words];
            logic [7:0] rd_byte_reg;
            always_ff @(posedge clk) begin
                if (accept && is_wr && wr_mask[gi]) begin
                    lane_mem[req_idx] <= wr_data[8*gi +: 8];
                end
                rd_byte_reg <= lane_mem[req_idx];
            end
            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_val_reg <= 1'b0;
        end else begin
            s0_val_reg <= accept;
        end
        s0_read_reg <= is_rd;
        s0_off_reg  <= req.addr[1:0];
        s0_resp_reg <= '{type_:  req.type_,
                         opaque: req.opaque,
                         test:   (is_rd || is_wr) ? MEM_TEST_OK : MEM_TEST_UNSUPPORTED,
                         len:    req.len,
                         data:   32'h0};
    end

    always_comb begin
        s0_resp_full = s0_resp_reg;
        if (s0_read_reg) begin
            s0_resp_full.data = rd_data;
        end
    end

    logic         pipe_val  [p_latency];
    mem_resp_4B_t pipe_resp [p_latency];

    assign pipe_val[0]  = s0_val_reg;
    assign pipe_resp[0] = s0_resp_full;

    generate
        for (gi = 1; gi < p_latency; gi++) begin : g_stage
            logic         val_reg;
            mem_resp_4B_t resp_reg;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    val_reg <= 1'b0;
                end else begin
                    val_reg <= pipe_val[gi-1];
                end
                resp_reg <= pipe_resp[gi-1];
            end
            assign pipe_val[gi]  = val_reg;
            assign pipe_resp[gi] = resp_reg;
        end
    endgenerate

    // Output buffer; the last pipeline stage bypasses it when empty so the
    // response is visible without an extra cycle.
    mem_resp_4B_t     buf_mem [p_resp_depth];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [3:0]       buf_cnt_reg;
    logic             buf_empty, head_val, enq, deq;
    mem_resp_4B_t     head_msg;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_resp_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign buf_empty      = (buf_cnt_reg == 4'd0);
    assign head_val       = !buf_empty || pipe_val[p_latency-1];
    assign head_msg       = buf_empty ? pipe_resp[p_latency-1] : buf_mem[rd_ptr_reg];
    assign respstream_val = reset && head_val && !stall;
    assign respstream_msg = head_msg;
    assign deliver        = respstream_val && respstream_rdy;
    assign enq            = pipe_val[p_latency-1] && !(buf_empty && deliver);
    assign deq            = !buf_empty && deliver;

    always_ff @(posedge clk) begin
        if (enq) begin
            buf_mem[wr_ptr_reg] <= pipe_resp[p_latency-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            buf_cnt_reg <= 4'd0;
            count_reg   <= 4'd0;
        end else begin
            if (enq) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (deq) rd_ptr_reg <= next_ptr(rd_ptr_reg);
            buf_cnt_reg <= buf_cnt_reg + 4'(enq) - 4'(deq);
            count_reg   <= count_reg + 4'(accept) - 4'(deliver);
        end
    end

`ifdef TEST_MEM_RESPONDER_RAND_DELAY_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {^(lfsr_reg & LFSR_TAPS), lfsr_reg[15:1]};
        end
    end

    assign stall = lfsr_reg[0];
`else
    assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_test_mem_responder.sv
// Scoreboard bench for test_mem_responder: byte-array reference model, queued
// driver, and an independent monitor that pops expected responses on delivery.
module tb_test_mem_responder;
    import test_mem_responder_pkg::*;

    localparam int L     = 2;
    localparam int DEPTH = 4;
    localparam int NW    = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [76:0] reqstream_msg = '0;
    logic        reqstream_val = 1'b0;
    logic        reqstream_rdy;
    logic [46:0] respstream_msg;
    logic        respstream_val;
    logic        respstream_rdy = 1'b0;
    logic [3:0]  num_outstanding;

    test_mem_responder #(.p_num_words(NW), .p_latency(L), .p_resp_depth(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .reqstream_msg   (reqstream_msg),
        .reqstream_val   (reqstream_val),
        .reqstream_rdy   (reqstream_rdy),
        .respstream_msg  (respstream_msg),
        .respstream_val  (respstream_val),
        .respstream_rdy  (respstream_rdy),
        .num_outstanding (num_outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_resp_4B_t resp;
        int           acc;
        bit           exact;
    } exp_t;

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            n_accepted = 0;
    int            model_out = 0;
    bit            exact_mode = 1'b0;
    bit            rand_rdy = 1'b0;
    bit [7:0]      model_mem [NW*4];
    mem_req_4B_t   tx_q [$];
    exp_t          exp_q [$];
    mem_resp_4B_t  last_resp;
    logic [7:0]    del_opq [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference model: memory as a flat byte array, one byte at a time.
    function automatic mem_resp_4B_t model_apply(input mem_req_4B_t r);
        mem_resp_4B_t rsp;
        int w   = int'((r.addr >> 2) % NW);
        int off = int'(r.addr % 4);
        int n   = (r.len == 2'd0) ? 4 : int'(r.len);
        logic [31:0] d = r.data;
        rsp.type_  = r.type_;
        rsp.opaque = r.opaque;
        rsp.len    = r.len;
        rsp.test   = 2'b00;
        rsp.data   = 32'h0;
        if (r.type_ == 3'd0) begin
            for (int i = 0; i < n; i++)
                if (off + i < 4) rsp.data = rsp.data | (32'(model_mem[w*4+off+i]) << (8*i));
        end else if (r.type_ == 3'd1 || r.type_ == 3'd2) begin
            for (int i = 0; i < n; i++)
                if (off + i < 4) model_mem[w*4+off+i] = 8'(d >> (8*i));
        end else begin
            rsp.test = 2'b01;
        end
        return rsp;
    endfunction

    task automatic send(input logic [2:0] t, input logic [31:0] a, input logic [1:0] ln,
                        input logic [31:0] d, input logic [7:0] opq);
        mem_req_4B_t r;
        r.type_ = t; r.addr = a; r.len = ln; r.data = d; r.opaque = opq;
        tx_q.push_back(r);
    endtask

    // Driver: presents the head of tx_q until it is accepted.
    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            acc = reset && reqstream_val && reqstream_rdy;
            @(posedge clk);
            #1;
            if (acc && tx_q.size() > 0) void'(tx_q.pop_front());
            if (tx_q.size() > 0) begin
                reqstream_msg = tx_q[0];
                reqstream_val = 1'b1;
            end else begin
                reqstream_val = 1'b0;
            end
        end
    end

    // Stimulus side of the scoreboard: each accept updates the model and queues its response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && reqstream_val && reqstream_rdy) begin
                e.resp  = model_apply(mem_req_4B_t'(reqstream_msg));
                e.acc   = cyc;
                e.exact = exact_mode;
                exp_q.push_back(e);
                n_accepted++;
            end
        end
    end

    // Monitor: checks outstanding count, hold stability and every delivered response.
    initial begin
        exp_t e;
        bit prev_hold = 1'b0;
        logic [46:0] prev_msg = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                model_out = 0;
                prev_hold = 1'b0;
            end else begin
                check("num_outstanding", 64'(num_outstanding), 64'(model_out));
                if (prev_hold && respstream_val) check("msg_stable", 64'(respstream_msg), 64'(prev_msg));
                prev_hold = respstream_val && !respstream_rdy;
                prev_msg  = respstream_msg;
                if (respstream_val && respstream_rdy) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_resp: got %0h, expected no response", respstream_msg);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_msg", 64'(respstream_msg), 64'(e.resp));
                        check("latency_min", 64'(cyc - e.acc >= L), 64'd1);
`ifndef TEST_MEM_RESPONDER_RAND_DELAY_EN
                        if (e.exact) check("latency_exact", 64'(cyc - e.acc), 64'(L));
`endif
                    end
                    last_resp = respstream_msg;
                    del_opq.push_back(last_resp.opaque);
                    model_out--;
                end
                if (reqstream_val && reqstream_rdy) model_out++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) respstream_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic wait_idle(input int budget);
        int k = 0;
        @(negedge clk);
        while ((tx_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: got %0d pending, expected 0", tx_q.size() + exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_outstanding(input int n);
        int k = 0;
        while (num_outstanding != 4'(n) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_outstanding", 64'(num_outstanding), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int acc0;
        mem_req_4B_t r;
        logic [2:0] t;

        repeat (3) @(negedge clk);
        check("reset_rdy", 64'(reqstream_rdy), 64'd0);
        check("reset_val", 64'(respstream_val), 64'd0);
        check("reset_cnt", 64'(num_outstanding), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        respstream_rdy = 1'b1;
        exact_mode = 1'b1;

        for (int w = 0; w < 16; w++) send(MEM_REQ_INIT, 32'h100 + 32'(w*4), 2'd0, $urandom, 8'(w));
        wait_idle(200);

        send(MEM_REQ_WRITE, 32'h100, 2'd0, 32'hDEADBEEF, 8'h20);
        send(MEM_REQ_READ,  32'h100, 2'd0, 32'h0, 8'h21);
        wait_idle(100);
        check("read_full", 64'(last_resp.data), 64'hDEADBEEF);

        send(MEM_REQ_WRITE, 32'h102, 2'd1, 32'h55, 8'h22);
        send(MEM_REQ_READ,  32'h100, 2'd0, 32'h0, 8'h23);
        wait_idle(100);
        check("read_after_byte_wr", 64'(last_resp.data), 64'hDE55BEEF);
        send(MEM_REQ_READ, 32'h103, 2'd1, 32'h0, 8'h24);
        wait_idle(100);
        check("read_byte3", 64'(last_resp.data), 64'h000000DE);

        send(3'd3, 32'h100, 2'd0, 32'h12345678, 8'h7A);
        wait_idle(100);
        check("unsup_type", 64'(last_resp.type_), 64'd3);
        check("unsup_opaque", 64'(last_resp.opaque), 64'h7A);
        check("unsup_test", 64'(last_resp.test), 64'd1);
        check("unsup_data", 64'(last_resp.data), 64'd0);
        send(MEM_REQ_READ, 32'h100, 2'd0, 32'h0, 8'h25);
        wait_idle(100);
        check("unsup_no_write", 64'(last_resp.data), 64'hDE55BEEF);

        // Backpressure: only DEPTH requests may be taken while responses are held.
        exact_mode = 1'b0;
        @(posedge clk); #1;
        respstream_rdy = 1'b0;
        acc0 = n_accepted;
        del_opq.delete();
        for (int i = 0; i < 6; i++) send(MEM_REQ_READ, 32'h100 + 32'(4*i), 2'd0, 32'h0, 8'(i));
        repeat (10) @(negedge clk);
        check("bp_accepted", 64'(n_accepted - acc0), 64'd4);
        check("bp_rdy", 64'(reqstream_rdy), 64'd0);
        check("bp_cnt", 64'(num_outstanding), 64'd4);
        @(posedge clk); #1;
        respstream_rdy = 1'b1;
        wait_idle(100);
        check("bp_all_accepted", 64'(n_accepted - acc0), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < del_opq.size()) check("bp_order", 64'(del_opq[i]), 64'(i));

        // Hold three outstanding, then accept and deliver together for ten cycles.
        @(posedge clk); #1;
        respstream_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(MEM_REQ_READ, 32'h110, 2'd0, 32'h0, 8'(8'h40 + i));
        wait_outstanding(3);
        @(negedge clk);
        for (int i = 0; i < 10; i++) send(MEM_REQ_READ, 32'h114, 2'd2, 32'h0, 8'(8'h50 + i));
        @(posedge clk); #1;
        respstream_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("overlap_cnt", 64'(num_outstanding), 64'd3);
        end
        wait_idle(100);

        // Reset with responses in flight; writes done at accept must survive.
        @(posedge clk); #1;
        respstream_rdy = 1'b0;
        send(MEM_REQ_WRITE, 32'h104, 2'd0, 32'h11112222, 8'h60);
        send(MEM_REQ_WRITE, 32'h108, 2'd0, 32'h33334444, 8'h61);
        send(MEM_REQ_WRITE, 32'h10C, 2'd0, 32'h55556666, 8'h62);
        wait_outstanding(3);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_flight_val", 64'(respstream_val), 64'd0);
        check("rst_flight_cnt", 64'(num_outstanding), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        respstream_rdy = 1'b1;
        send(MEM_REQ_READ, 32'h108, 2'd0, 32'h0, 8'h63);
        wait_idle(100);
        check("rst_persist", 64'(last_resp.data), 64'h33334444);

        // Randomized traffic over 16 words, with aliasing upper address bits.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: t = MEM_REQ_READ;
                4, 5, 6:    t = MEM_REQ_WRITE;
                7:          t = MEM_REQ_INIT;
                default:    t = 3'($urandom_range(3, 7));
            endcase
            r.addr = 32'h100 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3))
                     | (32'($urandom_range(0, 15)) << 12);
            send(t, r.addr, 2'($urandom_range(0, 3)), $urandom, 8'($urandom));
        end
        wait_idle(5000);
        rand_rdy = 1'b0;
        @(posedge clk); #1;
        respstream_rdy = 1'b1;
        repeat (5) @(negedge clk);
        check("final_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
